maxt_hist_reader: RTL and testbench
===================================

Name: maxt_hist_reader

Overview:
- Read-side companion to the max-of-t histogram accumulator.
- On a start request, snapshots the 32 bin counters and the total-sample counter in one cycle; the accumulator keeps running afterwards.
- Streams the snapshot as a framed sequence of 32-bit words on a valid/ready stream toward the host link (UART/PCIe bridge).
- Frame: header, total, per-bin counts, then an XOR checksum, with last flagged.

Parameters:
- NBINS, 32, number of histogram bins (one per max[31:27] value).
- CW, 64, bin/total counter width; must equal 2*DW.
- DW, 32, output word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to snapshot and send a frame.
- bins_in  in  NBINS x CW  live histogram bin counters.
- total_in  in  CW  live total-sample counter.
- m_data  out  DW  stream data word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts word when m_valid && m_ready.
- m_last  out  1  high with the checksum word (final word of frame).
- busy  out  1  high from snapshot until the last word is accepted.
- done  out  1  one-cycle pulse the cycle after the last-word handshake.
- seq  out  8  sequence number of the next frame.

Behaviour:
- Reset values: m_data=0, m_valid=0, m_last=0, busy=0, done=0, seq=0, state=IDLE, checksum=0, snapshot registers=0.
- States: IDLE, SNAP, HDR, TOT, BIN, CSUM.
- IDLE -> SNAP when start=1. start in any other state is ignored (not queued).
- SNAP (1 cycle):
  - Register all bins_in and total_in into snapshot storage.
  - Clear checksum; busy=1.
  - -> HDR.
- HDR: m_data = {16'hA5A5, NBINS[7:0], seq}, m_valid=1.
- TOT: two words, low half total[31:0] first, then high half total[63:32].
- BIN: 2*NBINS words in the order bin0 lo, bin0 hi, bin1 lo, ... bin31 hi. Index counter is 6 bits and never wraps within a frame.
- CSUM: m_data = XOR of every previously sent word of this frame (header included), m_last=1.
- Advance rule:
  - A word advances only on m_valid && m_ready.
  - While m_valid && !m_ready, m_data and m_last hold stable.
  - m_valid never drops mid-frame.
  - No bubbles: next word presented the cycle after the handshake.
- Checksum accumulates at each handshake of a non-CSUM word.
- Frame length: 1 + 2 + 2*NBINS + 1 = 68 words. Minimum latency from start to first m_valid is 2 cycles (SNAP then HDR).
- On the CSUM handshake:
  - -> IDLE, m_valid=0, busy=0.
  - done=1 the next cycle.
  - seq increments mod 256 (255 -> 0).
- start in the same cycle as the CSUM handshake is ignored; start on the done cycle is accepted.
- Snapshot isolation: changes on bins_in/total_in after SNAP never affect the current frame.
- Reset mid-frame forces all reset values immediately. The partial frame is abandoned and seq is not incremented.

Decomposition:
- Package maxt_pkg holds:
  - NBINS, CW, DW defaults.
  - HDR_MAGIC = 16'hA5A5.
  - FRAME_WORDS = 68.
  - State enum typedef (IDLE, SNAP, HDR, TOT, BIN, CSUM).
- One sub-module, maxt_word_mux: combinational selection of the current DW word from the snapshot by state and index (lo/hi select on index[0], bin on index[5:1]).
- FSM, counters, checksum and handshake stay in maxt_hist_reader.

Test Plan:
- Basic frame: reset; bins_in[k]=k+1, total_in=64'h1_0000_0010; start; m_ready=1 constantly. Expect:
  - 68 consecutive words, first = 32'hA5A5_2000.
  - Then 32'h0000_0010, 32'h0000_0001, then bin pairs (1,0), (2,0) ... (32,0).
  - Last = XOR of all 67 words, m_last only on word 68.
  - done pulse after; seq=1.
- Backpressure: same stimulus, m_ready random 30% high. Expect:
  - Identical 68-word sequence.
  - m_data stable while stalled; no m_valid drop mid-frame.
- Snapshot isolation: start, then on the cycle after SNAP set all bins_in=64'hFFFF_FFFF_FFFF_FFFF. Frame still carries the pre-change values.
- Ignored start: pulse start at words 5 and 67 (the CSUM handshake cycle). Only one frame is sent; start on the done cycle produces a second frame with header 32'hA5A5_2001.
- Sequence wrap: run 256 frames. Frame 256 header = 32'hA5A5_20FF, then seq reads 0.
- Reset mid-frame: assert rst at word 30 with m_ready=1. Expect:
  - m_valid=0, busy=0, seq unchanged at 0 during reset.
  - After release, a new start yields a full 68-word frame with header seq=0.

Source files
------------

// File: rtl/maxt_pkg.sv
// Shared constants and types for the max-of-t histogram reader.
// Frame layout: header, total lo/hi, bin lo/hi pairs, XOR checksum.
package maxt_pkg;

    localparam int NBINS = 32;
    localparam int CW    = 64;
    localparam int DW    = 32;

    localparam logic [15:0] HDR_MAGIC   = 16'hA5A5;
    localparam int          FRAME_WORDS = 1 + 2 + 2 * NBINS + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SNAP = 3'd1,
        HDR  = 3'd2,
        TOT  = 3'd3,
        BIN  = 3'd4,
        CSUM = 3'd5
    } state_t;

endpackage

// File: rtl/maxt_if.sv
// Word stream toward the host link. A word transfers on a clock edge where
// m_valid && m_ready; once raised, m_valid, m_data and m_last hold until that edge.
interface maxt_if #(
    parameter int DW = 32
);
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/maxt_word_mux.sv
// Selects the outgoing word from the snapshot by state and word index.
// idx[0] picks the low/high half; idx[IDX_W-1:1] picks the bin.
module maxt_word_mux
    import maxt_pkg::*;
#(
    parameter int NBINS = maxt_pkg::NBINS,
    parameter int CW    = maxt_pkg::CW,
    parameter int DW    = maxt_pkg::DW,
    parameter int IDX_W = $clog2(2 * NBINS)
) (
    input  state_t                      state,
    input  logic [IDX_W-1:0]            idx,
    input  logic [7:0]                  seq,
    input  logic [DW-1:0]               csum,
    input  logic [NBINS-1:0][CW-1:0]    snap_bins,
    input  logic [CW-1:0]               snap_total,
    output logic [DW-1:0]               word
);

    logic [7:0]    nbins_b;
    logic [CW-1:0] sel_bin;

    assign nbins_b = 8'(NBINS);
    assign sel_bin = snap_bins[idx[IDX_W-1:1]];

    always_comb begin
        word = '0;
        case (state)
            HDR:     word = DW'({HDR_MAGIC, nbins_b, seq});
            TOT:     word = idx[0] ? snap_total[CW-1:DW] : snap_total[DW-1:0];
            BIN:     word = idx[0] ? sel_bin[CW-1:DW] : sel_bin[DW-1:0];
            CSUM:    word = csum;
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/maxt_hist_reader.sv
// Snapshots the live histogram on start and streams it as one framed,
// checksummed sequence of words; the accumulator keeps counting meanwhile.
module maxt_hist_reader
    import maxt_pkg::*;
#(
    parameter int NBINS = maxt_pkg::NBINS,
    parameter int CW    = maxt_pkg::CW,
    parameter int DW    = maxt_pkg::DW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NBINS-1:0][CW-1:0]  bins_in,
    input  logic [CW-1:0]             total_in,
    maxt_if.master                    m,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                seq,
    output state_t                    state
);

    localparam int IDX_W = $clog2(2 * NBINS);
    localparam logic [IDX_W-1:0] LAST_BIN_IDX = IDX_W'(2 * NBINS - 1);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DW-1:0]             csum_q, csum_d;
    logic [7:0]                seq_q, seq_d;
    logic                      done_q, done_d;
    logic                      snap_en;
    logic [NBINS-1:0][CW-1:0]  snap_bins;
    logic [CW-1:0]             snap_total;
    logic [DW-1:0]             word;
    logic                      valid;
    logic                      hs;

    maxt_word_mux #(
        .NBINS (NBINS),
        .CW    (CW),
        .DW    (DW),
        .IDX_W (IDX_W)
    ) u_word_mux (
        .state      (state_q),
        .idx        (idx_q),
        .seq        (seq_q),
        .csum       (csum_q),
        .snap_bins  (snap_bins),
        .snap_total (snap_total),
        .word       (word)
    );

    // Valid comes straight from the state register, so it cannot drop mid-frame.
    assign valid = (state_q == HDR) || (state_q == TOT) ||
                   (state_q == BIN) || (state_q == CSUM);
    assign hs    = valid && m.m_ready;

    assign m.m_data  = word;
    assign m.m_valid = valid;
    assign m.m_last  = (state_q == CSUM);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign seq       = seq_q;
    assign state     = state_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        seq_d   = seq_q;
        snap_en = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SNAP;
            end
            SNAP: begin
                snap_en = 1'b1;
                csum_d  = '0;
                idx_d   = '0;
                state_d = HDR;
            end
            HDR: begin
                if (hs) begin
                    csum_d  = csum_q ^ word;
                    idx_d   = '0;
                    state_d = TOT;
                end
            end
            TOT: begin
                if (hs) begin
                    csum_d = csum_q ^ word;
                    if (idx_q[0]) begin
                        idx_d   = '0;
                        state_d = BIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            BIN: begin
                if (hs) begin
                    csum_d = csum_q ^ word;
                    if (idx_q == LAST_BIN_IDX) begin
                        state_d = CSUM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            CSUM: begin
                // A start arriving on this cycle is dropped: the FSM is not IDLE yet.
                if (hs) begin
                    state_d = IDLE;
                    seq_d   = seq_q + 8'd1;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            seq_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            seq_q   <= seq_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_bins  <= '0;
            snap_total <= '0;
        end else if (snap_en) begin
            snap_bins  <= bins_in;
            snap_total <= total_in;
        end
    end

endmodule

// File: tb/tb_maxt_hist_reader.sv
// Directed bench for maxt_hist_reader: table of frame configurations plus
// hand-written sequences for isolation, ignored start, reset and seq wrap.
module tb_maxt_hist_reader;
    import maxt_pkg::*;

    typedef struct {
        logic [63:0] total;
        logic [63:0] mul;
        logic [63:0] add;
        int          pct;
        logic [31:0] hdr;
        logic [7:0]  seq_after;
    } vec_t;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic [7:0]                seq;
    state_t                    state;
    logic [NBINS-1:0][CW-1:0]  bins_in;
    logic [CW-1:0]             total_in;

    maxt_if #(.DW(DW)) m_if ();

    int            n_checks  = 0;
    int            n_pass    = 0;
    int            ready_pct = 100;
    int            hs_cnt    = 0;
    logic [DW:0]   exp_q[$];
    logic          prev_stall = 1'b0;
    logic          prev_hs    = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    vec_t          vecs[4];

    maxt_hist_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bins_in  (bins_in),
        .total_in (total_in),
        .m        (m_if),
        .busy     (busy),
        .done     (done),
        .seq      (seq),
        .state    (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // driver tasks
    initial begin
        m_if.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_if.m_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    task automatic set_bins(input logic [63:0] tot, input logic [63:0] mul, input logic [63:0] add);
        total_in = tot;
        for (int k = 0; k < NBINS; k++) bins_in[k] = 64'(k) * mul + add;
    endtask

    task automatic push_frame(input logic [31:0] hdr);
        logic [31:0] cs;
        cs = hdr;
        exp_q.push_back({1'b0, hdr});
        exp_q.push_back({1'b0, total_in[31:0]});
        cs = cs ^ total_in[31:0];
        exp_q.push_back({1'b0, total_in[63:32]});
        cs = cs ^ total_in[63:32];
        for (int k = 0; k < NBINS; k++) begin
            exp_q.push_back({1'b0, bins_in[k][31:0]});
            exp_q.push_back({1'b0, bins_in[k][63:32]});
            cs = cs ^ bins_in[k][31:0] ^ bins_in[k][63:32];
        end
        exp_q.push_back({1'b1, cs});
    endtask

    task automatic pulse_start(input bit corrupt);
        @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        chk("snap_state", 64'(state), 64'(SNAP));
        chk("snap_busy", 64'(busy), 64'd1);
        chk("snap_no_valid", 64'(m_if.m_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("hdr_latency_valid", 64'(m_if.m_valid), 64'd1);
        if (corrupt) begin
            total_in = '1;
            for (int k = 0; k < NBINS; k++) bins_in[k] = '1;
        end
    endtask

    task automatic wait_done(input logic [7:0] exp_seq, input bit next_start);
        int cyc;
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy_low", 64'(busy), 64'd0);
        chk("done_valid_low", 64'(m_if.m_valid), 64'd0);
        chk("seq_after_frame", 64'(seq), 64'(exp_seq));
        chk("frame_words_consumed", 64'(exp_q.size()), next_start ? 64'(FRAME_WORDS) : 64'd0);
        if (next_start) start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic wait_hs(input int n);
        int cyc;
        cyc = 0;
        while (hs_cnt < n && cyc < 4000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("reach_word", 64'(hs_cnt), 64'(n));
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            prev_hs    <= 1'b0;
            hs_cnt     <= 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(m_if.m_valid), 64'd1);
                chk("stall_data", 64'(m_if.m_data), 64'(prev_data));
                chk("stall_last", 64'(m_if.m_last), 64'(prev_last));
            end
            if (prev_hs) chk("no_bubble", 64'(m_if.m_valid), 64'd1);
            prev_hs <= 1'b0;
            if (m_if.m_valid && m_if.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(m_if.m_data), 64'hDEAD_0000_0000_0000);
                end else begin
                    chk("word", 64'(m_if.m_data), 64'(exp_q[0][DW-1:0]));
                    chk("last", 64'(m_if.m_last), 64'(exp_q[0][DW]));
                    void'(exp_q.pop_front());
                end
                if (m_if.m_last) hs_cnt <= 0;
                else begin
                    hs_cnt  <= hs_cnt + 1;
                    prev_hs <= 1'b1;
                end
            end
            prev_stall <= m_if.m_valid && !m_if.m_ready;
            prev_data  <= m_if.m_data;
            prev_last  <= m_if.m_last;
        end
    end

    initial begin
        vecs[0] = '{64'h1_0000_0010, 64'd1, 64'd1, 100, 32'hA5A5_2000, 8'd1};
        vecs[1] = '{64'h1_0000_0010, 64'd1, 64'd1, 30, 32'hA5A5_2001, 8'd2};
        vecs[2] = '{64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001, 50, 32'hA5A5_2002, 8'd3};
        vecs[3] = '{64'd0, 64'd0, 64'd0, 100, 32'hA5A5_2003, 8'd4};

        rst = 1'b1;
        start = 1'b0;
        set_bins(64'd0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        chk("rst_data", 64'(m_if.m_data), 64'd0);
        chk("rst_valid", 64'(m_if.m_valid), 64'd0);
        chk("rst_last", 64'(m_if.m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_seq", 64'(seq), 64'd0);
        chk("rst_state", 64'(state), 64'(IDLE));
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_valid", 64'(m_if.m_valid), 64'd0);

        // table of frames
        for (int i = 0; i < 4; i++) begin
            ready_pct = vecs[i].pct;
            set_bins(vecs[i].total, vecs[i].mul, vecs[i].add);
            push_frame(vecs[i].hdr);
            chk("model_first_word", 64'(exp_q[0][DW-1:0]), 64'(vecs[i].hdr));
            pulse_start(1'b0);
            wait_done(vecs[i].seq_after, 1'b0);
        end
        ready_pct = 100;

        // snapshot isolation
        set_bins(64'h1_0000_0010, 64'd1, 64'd1);
        push_frame(32'hA5A5_2004);
        pulse_start(1'b1);
        wait_done(8'd5, 1'b0);
        set_bins(64'h1_0000_0010, 64'd1, 64'd1);

        // ignored start mid-frame and on the CSUM handshake
        push_frame(32'hA5A5_2005);
        pulse_start(1'b0);
        wait_hs(5);
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (state != CSUM && cyc < 4000) begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        chk("reach_csum", 64'(state), 64'(CSUM));
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        chk("csum_start_done", 64'(done), 64'd1);
        chk("csum_start_seq", 64'(seq), 64'd6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("ignored_start_valid", 64'(m_if.m_valid), 64'd0);
            chk("ignored_start_busy", 64'(busy), 64'd0);
        end
        chk("ignored_start_queue", 64'(exp_q.size()), 64'd0);

        // start on the done cycle is accepted
        push_frame(32'hA5A5_2006);
        pulse_start(1'b0);
        push_frame(32'hA5A5_2007);
        wait_done(8'd7, 1'b1);
        wait_done(8'd8, 1'b0);

        // reset mid-frame
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        push_frame(32'hA5A5_2000);
        pulse_start(1'b0);
        wait_hs(30);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(m_if.m_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_seq", 64'(seq), 64'd0);
        chk("midrst_last", 64'(m_if.m_last), 64'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        chk("midrst_hold_state", 64'(state), 64'(IDLE));
        chk("midrst_hold_seq", 64'(seq), 64'd0);
        rst = 1'b0;
        push_frame(32'hA5A5_2000);
        pulse_start(1'b0);
        wait_done(8'd1, 1'b0);

        // sequence wrap: frames 2..256 after the reset
        for (int i = 1; i < 256; i++) begin
            push_frame({16'hA5A5, 8'h20, 8'(i)});
            pulse_start(1'b0);
            wait_done(8'(i + 1), 1'b0);
        end
        chk("seq_wrapped", 64'(seq), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
